// File: rtl/shift_counter_pkg.sv
// Shared constants and seed helper for the shift-register counter family.
package shift_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  // Ring seeds with bit 0 set; Johnson seeds with all zeros.
  function automatic logic [31:0] seed(input logic mode, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (mode == MODE_JOHNSON) ? 32'd0 : (32'd1 & mask);
  endfunction

endpackage

// File: rtl/shift_counter_legal_check.sv
// Combinational legality check of a ring or Johnson counter state.
module shift_counter_legal_check
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             legal
);

  logic [5:0] ones;
  logic [5:0] edges;

  // A Johnson state has at most one 0/1 boundary; a ring state is one-hot.
  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + 6'(q[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      edges = edges + 6'(q[i] ^ q[i+1]);
    end
    legal = (mode == MODE_JOHNSON) ? (edges <= 6'd1) : (ones == 6'd1);
  end

endmodule

// File: rtl/shift_counter.sv
// Ring / Johnson shift counter with direction, parallel load, wrap pulse
// and self-correction of illegal states on the next enabled step.
module shift_counter
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Mode,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_value,
  output logic [WIDTH-1:0] Count_out,
  output logic             Wrap,
  output logic             Error
);

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] q,
                                            input logic mode,
                                            input logic dir);
    logic fb_left;
    logic fb_right;
    fb_left  = (mode == MODE_JOHNSON) ? ~q[WIDTH-1] : q[WIDTH-1];
    fb_right = (mode == MODE_JOHNSON) ? ~q[0]       : q[0];
    return (dir == DIR_RIGHT) ? {fb_right, q[WIDTH-1:1]} : {q[WIDTH-2:0], fb_left};
  endfunction

  logic [WIDTH-1:0] seed_w;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             error_nxt;
  logic             legal;

  shift_counter_legal_check #(.WIDTH(WIDTH)) u_legal (
    .q     (Count_out),
    .mode  (Mode),
    .legal (legal)
  );

  assign seed_w  = WIDTH'(seed(Mode, WIDTH));
  assign stepped = step(Count_out, Mode, Dir);

  always_comb begin
    count_nxt = Count_out;
    wrap_nxt  = 1'b0;
    error_nxt = 1'b0;
    if (Reset) begin
      count_nxt = seed_w;
    end else if (Load) begin
      count_nxt = Load_value;
    end else if (Enable) begin
      if (legal) begin
        count_nxt = stepped;
        wrap_nxt  = (stepped == seed_w);
      end else begin
        count_nxt = seed_w;
        error_nxt = 1'b1;
      end
    end
  end

  // Register stage: state, wrap and error stay aligned.
  always_ff @(posedge Clock) begin
    Count_out <= count_nxt;
    Wrap      <= wrap_nxt;
    Error     <= error_nxt;
  end

endmodule

// File: tb/tb_shift_counter.sv
// Scoreboard bench for shift_counter (WIDTH=4 and WIDTH=8 instances).
module tb_shift_counter;

  typedef struct packed {
    logic [7:0] c;
    logic       w;
    logic       e;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset, Enable, Mode, Dir, Load;
  logic [3:0] Load_value;
  logic [7:0] load_value8;
  logic [3:0] Count_out;
  logic [7:0] count8;
  logic       Wrap, Error, wrap8, error8;

  exp_t sb[$];
  exp_t ex;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 Clock = ~Clock;

  shift_counter #(.WIDTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Mode(Mode), .Dir(Dir),
    .Load(Load), .Load_value(Load_value), .Count_out(Count_out),
    .Wrap(Wrap), .Error(Error)
  );

  shift_counter #(.WIDTH(8)) dut8 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Mode(Mode), .Dir(Dir),
    .Load(Load), .Load_value(load_value8), .Count_out(count8),
    .Wrap(wrap8), .Error(error8)
  );

  // Inputs change 1 time unit after a rising edge and are sampled at the next.
  task automatic drive(input logic r, input logic l, input logic e,
                       input logic m, input logic d, input logic [3:0] lv);
    Reset = r; Load = l; Enable = e; Mode = m; Dir = d; Load_value = lv;
  endtask

  task automatic test_reset();
    logic [3:0] want [3] = '{4'b0001, 4'b0000, 4'b0001};
    drive(1, 0, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) drive(1, 0, 0, 1, 0, 4'b0000);
      if (i == 2) drive(1, 1, 1, 0, 0, 4'b1000);
      sb.push_back('{c: {4'b0, want[i]}, w: 1'b0, e: 1'b0});
      @(posedge Clock); #1;
      ex = sb.pop_front();
      n_cmp++;
      if ({4'b0, Count_out} !== ex.c || Wrap !== ex.w || Error !== ex.e) begin
        n_err++;
        $display("FAIL reset[%0d]: got %b w%b e%b, want %b w%b e%b",
                 i, Count_out, Wrap, Error, ex.c[3:0], ex.w, ex.e);
      end
    end
  endtask

  task automatic test_ring_left();
    logic [3:0] want [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    drive(1, 0, 0, 0, 0, 4'b0000);
    @(posedge Clock); #1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0, 4'b0000);
      sb.push_back('{c: {4'b0, want[i]}, w: (i == 3), e: 1'b0});
      @(posedge Clock); #1;
      ex = sb.pop_front();
      n_cmp++;
      if ({4'b0, Count_out} !== ex.c || Wrap !== ex.w || Error !== ex.e) begin
        n_err++;
        $display("FAIL ring_left[%0d]: got %b w%b e%b, want %b w%b e%b",
                 i, Count_out, Wrap, Error, ex.c[3:0], ex.w, ex.e);
      end
    end
  endtask

  task automatic test_johnson();
    logic [3:0] left_seq  [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                  4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [3:0] right_seq [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                  4'b0111, 4'b0011, 4'b0001, 4'b0000};
    drive(1, 0, 0, 1, 0, 4'b0000);
    @(posedge Clock); #1;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 1, (i >= 8), 4'b0000);
      sb.push_back('{c: {4'b0, (i < 8) ? left_seq[i] : right_seq[i-8]},
                     w: (i == 7 || i == 15), e: 1'b0});
      @(posedge Clock); #1;
      ex = sb.pop_front();
      n_cmp++;
      if ({4'b0, Count_out} !== ex.c || Wrap !== ex.w || Error !== ex.e) begin
        n_err++;
        $display("FAIL johnson[%0d]: got %b w%b e%b, want %b w%b e%b",
                 i, Count_out, Wrap, Error, ex.c[3:0], ex.w, ex.e);
      end
    end
  endtask

  task automatic test_illegal_load();
    drive(1, 0, 0, 0, 0, 4'b0000);
    @(posedge Clock); #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        drive(0, 1, 1, 0, 0, 4'b0110);
        sb.push_back('{c: 8'b0110, w: 1'b0, e: 1'b0});
      end else if (i == 1) begin
        drive(0, 0, 1, 0, 0, 4'b0000);
        sb.push_back('{c: 8'b0001, w: 1'b0, e: 1'b1});
      end else begin
        drive(0, 0, 1, 0, 0, 4'b0000);
        sb.push_back('{c: 8'b0010, w: 1'b0, e: 1'b0});
      end
      @(posedge Clock); #1;
      ex = sb.pop_front();
      n_cmp++;
      if ({4'b0, Count_out} !== ex.c || Wrap !== ex.w || Error !== ex.e) begin
        n_err++;
        $display("FAIL illegal_load[%0d]: got %b w%b e%b, want %b w%b e%b",
                 i, Count_out, Wrap, Error, ex.c[3:0], ex.w, ex.e);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [3:0] want [4] = '{4'b0010, 4'b0100, 4'b0000, 4'b0001};
    logic       err  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    drive(1, 0, 0, 0, 0, 4'b0000);
    @(posedge Clock); #1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, (i >= 2), 0, 4'b0000);
      sb.push_back('{c: {4'b0, want[i]}, w: 1'b0, e: err[i]});
      @(posedge Clock); #1;
      ex = sb.pop_front();
      n_cmp++;
      if ({4'b0, Count_out} !== ex.c || Wrap !== ex.w || Error !== ex.e) begin
        n_err++;
        $display("FAIL mode_switch[%0d]: got %b w%b e%b, want %b w%b e%b",
                 i, Count_out, Wrap, Error, ex.c[3:0], ex.w, ex.e);
      end
    end
  endtask

  task automatic test_load_priority();
    drive(0, 1, 1, 0, 0, 4'b1000);
    sb.push_back('{c: 8'b1000, w: 1'b0, e: 1'b0});
    @(posedge Clock); #1;
    ex = sb.pop_front();
    n_cmp++;
    if ({4'b0, Count_out} !== ex.c || Wrap !== ex.w || Error !== ex.e) begin
      n_err++;
      $display("FAIL load_over_enable: got %b w%b e%b, want %b w%b e%b",
               Count_out, Wrap, Error, ex.c[3:0], ex.w, ex.e);
    end
  endtask

  task automatic test_hold();
    drive(0, 1, 0, 0, 0, 4'b0100);
    @(posedge Clock); #1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 4'b1111);
      sb.push_back('{c: 8'b0100, w: 1'b0, e: 1'b0});
      @(posedge Clock); #1;
      ex = sb.pop_front();
      n_cmp++;
      if ({4'b0, Count_out} !== ex.c || Wrap !== ex.w || Error !== ex.e) begin
        n_err++;
        $display("FAIL hold[%0d]: got %b w%b e%b, want %b w%b e%b",
                 i, Count_out, Wrap, Error, ex.c[3:0], ex.w, ex.e);
      end
    end
  endtask

  task automatic test_wrap8();
    drive(1, 0, 0, 0, 0, 4'b0000);
    @(posedge Clock); #1;
    for (int k = 1; k <= 24; k++) begin
      drive(0, 0, 1, 0, 0, 4'b0000);
      sb.push_back('{c: 8'd1 << (k % 8), w: (k % 8 == 0), e: 1'b0});
      @(posedge Clock); #1;
      ex = sb.pop_front();
      n_cmp++;
      if (count8 !== ex.c || wrap8 !== ex.w || error8 !== ex.e) begin
        n_err++;
        $display("FAIL wrap8[%0d]: got %b w%b e%b, want %b w%b e%b",
                 k, count8, wrap8, error8, ex.c, ex.w, ex.e);
      end
    end
  endtask

  initial begin
    load_value8 = 8'h00;
    drive(1, 0, 0, 0, 0, 4'b0000);
    @(posedge Clock); #1;
    test_reset();
    test_ring_left();
    test_johnson();
    test_illegal_load();
    test_mode_switch();
    test_load_priority();
    test_hold();
    test_wrap8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
